// File: rtl/bram_access_ctrl.sv
// Load/store front end for the single-port 32-bit data BRAM: sub-word stores use read-modify-write,
// and loads are lane-extracted and extended. Each accepted request gets exactly one response pulse.
module bram_access_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int RAM_DEPTH    = 750,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic              mem_regce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [29:0] DEPTH_LIM = 30'(RAM_DEPTH);
  localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY - 1);

  state_t              r_state, w_state_next;
  logic                r_we, w_we_next;
  logic [1:0]          r_size, w_size_next;
  logic                r_signed, w_signed_next;
  logic [1:0]          r_lane, w_lane_next;
  logic [31:0]         r_wdata, w_wdata_next;
  logic [1:0]          r_lat, w_lat_next;
  logic                r_rsp_valid, w_rsp_valid_next;
  logic                r_rsp_err, w_rsp_err_next;
  logic [31:0]         r_rsp_rdata, w_rsp_rdata_next;
  logic                r_mem_en, w_mem_en_next;
  logic                r_mem_wen, w_mem_wen_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [31:0]         r_mem_wdata, w_mem_wdata_next;

  logic                w_accept;
  logic                w_bad;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;

  assign req_ready = (r_state == IDLE) && rst;
  assign mem_regce = (READ_LATENCY == 2);
  assign w_accept  = req_valid && req_ready;

  // Range check uses the full word index so high address bits cannot alias into the BRAM.
  assign w_bad = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (req_addr[31:2] >= DEPTH_LIM);

  always_comb begin
    w_byte   = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half   = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    w_load   = mem_rdata;
    w_merged = mem_rdata;
    case (r_size)
      2'b00: begin
        w_load = {{24{r_signed & w_byte[7]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{r_signed & w_half[15]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_we_next        = r_we;
    w_size_next      = r_size;
    w_signed_next    = r_signed;
    w_lane_next      = r_lane;
    w_wdata_next     = r_wdata;
    w_lat_next       = r_lat;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_rdata_next = r_rsp_rdata;
    w_mem_en_next    = r_mem_en;
    w_mem_wen_next   = r_mem_wen;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_we_next     = req_we;
          w_size_next   = req_size;
          w_signed_next = req_signed;
          w_lane_next   = req_addr[1:0];
          w_wdata_next  = req_wdata;
          w_lat_next    = 2'd0;
          if (w_bad) begin
            w_state_next     = RESP;
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
            w_rsp_rdata_next = 32'd0;
          end else if (req_we && req_size == 2'b10) begin
            w_state_next     = WR;
            w_mem_en_next    = 1'b1;
            w_mem_wen_next   = 1'b1;
            w_mem_addr_next  = req_addr[ADDR_W+1:2];
            w_mem_wdata_next = req_wdata;
          end else begin
            w_state_next    = RD;
            w_mem_en_next   = 1'b1;
            w_mem_wen_next  = 1'b0;
            w_mem_addr_next = req_addr[ADDR_W+1:2];
          end
        end
      end
      RD: begin
        if (r_lat == LAT_LAST) begin
          if (r_we) begin
            w_state_next     = WR;
            w_mem_wen_next   = 1'b1;
            w_mem_wdata_next = w_merged;
          end else begin
            w_state_next     = RESP;
            w_mem_en_next    = 1'b0;
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b0;
            w_rsp_rdata_next = w_load;
          end
        end else begin
          w_lat_next = r_lat + 2'd1;
        end
      end
      WR: begin
        w_state_next     = RESP;
        w_mem_en_next    = 1'b0;
        w_mem_wen_next   = 1'b0;
        w_rsp_valid_next = 1'b1;
        w_rsp_err_next   = 1'b0;
        w_rsp_rdata_next = 32'd0;
      end
      RESP: begin
        w_state_next     = IDLE;
        w_rsp_valid_next = 1'b0;
        w_rsp_err_next   = 1'b0;
        w_rsp_rdata_next = 32'd0;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 32'd0;
      r_lat       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_mem_en    <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_we        <= w_we_next;
      r_size      <= w_size_next;
      r_signed    <= w_signed_next;
      r_lane      <= w_lane_next;
      r_wdata     <= w_wdata_next;
      r_lat       <= w_lat_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_wen   <= w_mem_wen_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/bram_access_ctrl.md
Name: bram_access_ctrl

Overview:
- Initiator-side controller that drives the single-port 32-bit data BRAM on behalf of the multi-cycle MIPS core.
- Converts byte/half/word load-store requests (byte address, size, signedness) into BRAM word accesses: aligned word writes directly, sub-word stores via read-modify-write.
- Performs load lane extraction and sign/zero extension, checks alignment and range, and returns one response per request.

Parameters:
ADDR_W, 12, BRAM word-address width
RAM_DEPTH, 750, number of valid BRAM words; word index >= RAM_DEPTH is out of range
READ_LATENCY, 1, edges from address issue to valid mem_rdata (1 = unregistered BRAM output, 2 = output-register variant)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept; equals (state==IDLE) && rst
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 = error
req_signed  in  1  sign-extend loads (ignored for word and stores)
req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2]
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_err  out  1  qualified by rsp_valid: misaligned, out-of-range or bad size
rsp_rdata  out  32  load result (0 for stores/errors)
mem_en  out  1  BRAM enable
mem_wen  out  1  BRAM write enable
mem_regce  out  1  constant (READ_LATENCY==2)
mem_addr  out  ADDR_W  BRAM word address
mem_wdata  out  32  BRAM write data
mem_rdata  in  32  BRAM read data

Behaviour:
- All outputs are registered, except req_ready and mem_regce.
- Reset (rst==0 at an edge): state=IDLE; rsp_valid, rsp_err, rsp_rdata, mem_en, mem_wen, mem_addr, mem_wdata = 0; lat counter = 0.
- Accept: req_valid && req_ready at edge A; request fields latched. Back-to-back requests only through IDLE.
- Error check at accept, in this order: size==11; half with addr[0]=1; word with addr[1:0]!=0; word index >= RAM_DEPTH (compare full req_addr[31:2]).
  - On error: go to RESP. mem_en stays 0. rsp_valid=1, rsp_err=1 in the cycle after A. IDLE after A+1.
- States: IDLE, RD, WR, RESP.
- Load: edge A -> RD; mem_en=1, mem_wen=0, mem_addr set.
  - At edge A+READ_LATENCY: capture mem_rdata and extract the lane. Byte lane = addr[1:0]; half lane = addr[1]; little-endian.
  - Extend per req_signed. Drive rsp_rdata, rsp_valid=1 -> RESP; mem_en=0.
- Word store: edge A -> WR; mem_en=1, mem_wen=1, mem_wdata=req_wdata.
  - Edge A+1: BRAM commits; mem_en/mem_wen=0; rsp_valid=1 -> RESP.
- Sub-word store: edge A -> RD as for a load.
  - At edge A+READ_LATENCY: merge. Byte replaces bits [8k+7:8k] with wdata[7:0]; half replaces [16h+15:16h] with wdata[15:0].
  - Then -> WR with mem_wen=1 and the merged data. Next edge commits -> RESP.
- RESP: rsp_valid high exactly one cycle; next edge -> IDLE, rsp_valid=0, rsp_err=0.
- Latency, accept edge to rsp_valid rising edge:
  - load: READ_LATENCY
  - word store: 1
  - sub-word store: READ_LATENCY+1
  - error: 0 (rsp_valid visible the cycle after accept)
- mem_addr/mem_wdata hold their value from issue until the next access; mem_en is asserted only in RD/WR.
- Reset mid-operation: a write whose mem_wen was already high before the reset edge commits at that edge. No response is ever issued for an aborted request. req_ready=0 while rst=0 and returns to 1 the cycle after release.
- req_valid while busy: ignored, not queued; the requester must hold it until the handshake.

Test Plan:
1. Word store 0xDEADBEEF @0x10, then word load @0x10 (READ_LATENCY=1) -> mem_wen pulse one cycle, addr 0x004; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 1 edge after accept.
2. sb 0x80 @0x13 on word 0xDEADBEEF -> RD then WR, mem_wdata=0x80ADBEEF. lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080.
3. sh 0x1234 @0x12 -> word 0x1234BEEF; lh signed @0x12 -> 0x00001234. Half @0x11 and word @0x12 -> rsp_err=1, mem_en never asserted.
4. Word load @0xBB4 (index 749) -> ok. @0xBB8 (index 750) and @0x4000_0000 -> rsp_err=1, no memory access. req_size=11 -> rsp_err=1.
5. Assert rst=0 at the edge ending WR for store 0x55AA55AA @0x20 -> memory word 8 = 0x55AA55AA, no rsp_valid, req_ready=0 during reset, 1 one cycle after release.
6. READ_LATENCY=2 instance, req_valid held high with two loads -> mem_regce=1; each rsp 2 edges after accept; second accepted only on the edge after RESP.
